// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | stopwatch_pkg : shared types and helpers for lap_stopwatch_core   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Bits needed to hold 10**digits-1 in binary.
    function automatic int tw_of(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lap_stopwatch_core_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lap_stopwatch_core_if : control pulses, lap read and time outputs |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface lap_stopwatch_core_if #(
    parameter int DIGITS = 6,
    parameter int LAPS   = 8
);
    import stopwatch_pkg::*;

    localparam int TW = tw_of(DIGITS);
    localparam int AW = $clog2(LAPS);
    localparam int CW = $clog2(LAPS + 1);

    logic                  start_stop;
    logic                  lap;
    logic                  clear;
    logic [AW-1:0]         rd_idx;
    logic [TW-1:0]         t;
    logic [4*DIGITS-1:0]   t_bcd;
    logic [TW-1:0]         t_interval;
    logic [TW-1:0]         lap_time;
    logic [CW-1:0]         lap_count;
    logic                  lap_ovf;
    logic                  running;
    logic                  t_ovf;

    modport master (
        output start_stop, lap, clear, rd_idx,
        input  t, t_bcd, t_interval, lap_time, lap_count, lap_ovf, running, t_ovf
    );

    modport slave (
        input  start_stop, lap, clear, rd_idx,
        output t, t_bcd, t_interval, lap_time, lap_count, lap_ovf, running, t_ovf
    );

endinterface
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | bcd_counter : saturating cascaded decade counter with binary twin |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int TW     = tw_of(DIGITS)
) (
    input  wire logic                clk,
    input  wire logic                KEY2,
    input  wire logic                clr,
    input  wire logic                inc,
    output logic [4*DIGITS-1:0]      bcd,
    output logic [TW-1:0]            bin,
    output logic                     sat
);

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [TW-1:0]       bin_q, bin_d;
    logic                sat_q, sat_d;
    logic                at_max;
    logic                carry;

    always_comb begin
        at_max = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != BCD_MAX_DIGIT) begin
                at_max = 1'b0;
            end
        end
    end

    // Binary and BCD advance in the same cycle so they never disagree.
    always_comb begin
        bcd_d = bcd_q;
        bin_d = bin_q;
        sat_d = sat_q;
        carry = 1'b0;
        if (clr) begin
            bcd_d = '0;
            bin_d = '0;
            sat_d = 1'b0;
        end else if (inc) begin
            if (at_max) begin
                sat_d = 1'b1;
            end else begin
                bin_d = bin_q + 1'b1;
                carry = 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    if (carry) begin
                        if (bcd_q[4*i +: 4] == BCD_MAX_DIGIT) begin
                            bcd_d[4*i +: 4] = 4'd0;
                        end else begin
                            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                            carry           = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!KEY2) begin
            bcd_q <= '0;
            bin_q <= '0;
            sat_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            sat_q <= sat_d;
        end
    end

    assign bcd = bcd_q;
    assign bin = bin_q;
    assign sat = sat_q;

endmodule
`default_nettype wire

// File: rtl/lap_stopwatch_core.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lap_stopwatch_core : run/pause/clear stopwatch with lap memory    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module lap_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int DIGITS  = 6,
    parameter int LAPS    = 8
) (
    input  wire logic            clk,
    input  wire logic            KEY2,
    lap_stopwatch_core_if.slave  bus
);

    localparam int TW  = tw_of(DIGITS);
    localparam int AW  = $clog2(LAPS);
    localparam int CW  = $clog2(LAPS + 1);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [CW-1:0] LAPS_C  = CW'(LAPS);

    sw_state_t     state_q, state_d;
    logic          running_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lovf_q, lovf_d;
    logic [TW-1:0] prev_q, prev_d;
    logic [TW-1:0] intv_q, intv_d;
    logic [TW-1:0] ltime_q, ltime_d;
    logic [TW-1:0] mem_q [LAPS];

    logic                clr_acc;
    logic                lap_acc;
    logic                tick;
    logic [AW-1:0]       rd_phys;
    logic                rd_hit;
    logic [TW-1:0]       t_bin;
    logic [4*DIGITS-1:0] t_bcd_w;
    logic                t_sat;

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_cnt (
        .clk  (clk),
        .KEY2 (KEY2),
        .clr  (clr_acc),
        .inc  (tick),
        .bcd  (t_bcd_w),
        .bin  (t_bin),
        .sat  (t_sat)
    );

    assign clr_acc = bus.clear && (state_q != RUN);
    assign lap_acc = bus.lap && (state_q == RUN);
    assign tick    = (state_q == RUN) && (pre_q == PRE_MAX);

    // Oldest stored entry sits lap_count slots behind the write pointer.
    assign rd_phys = wp_q - cnt_q[AW-1:0] + bus.rd_idx;
    assign rd_hit  = CW'(bus.rd_idx) < cnt_q;

    always_comb begin
        state_d = state_q;
        if (clr_acc) begin
            state_d = IDLE;
        end else if (bus.start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pre_d = pre_q;
        if (clr_acc) begin
            pre_d = '0;
        end else if (state_q == RUN) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_comb begin
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        lovf_d  = lovf_q;
        prev_d  = prev_q;
        intv_d  = intv_q;
        ltime_d = rd_hit ? mem_q[rd_phys] : '0;
        if (clr_acc) begin
            wp_d    = '0;
            cnt_d   = '0;
            lovf_d  = 1'b0;
            prev_d  = '0;
            intv_d  = '0;
            ltime_d = '0;
        end else if (lap_acc) begin
            wp_d   = wp_q + 1'b1;
            intv_d = t_bin - prev_q;
            prev_d = t_bin;
            if (cnt_q == LAPS_C) begin
                lovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!KEY2) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            pre_q     <= '0;
            wp_q      <= '0;
            cnt_q     <= '0;
            lovf_q    <= 1'b0;
            prev_q    <= '0;
            intv_q    <= '0;
            ltime_q   <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
            pre_q     <= pre_d;
            wp_q      <= wp_d;
            cnt_q     <= cnt_d;
            lovf_q    <= lovf_d;
            prev_q    <= prev_d;
            intv_q    <= intv_d;
            ltime_q   <= ltime_d;
        end
    end

    // Stale contents are harmless: lap_count gates every read.
    always_ff @(posedge clk) begin
        if (KEY2 && lap_acc) begin
            mem_q[wp_q] <= t_bin;
        end
    end

    assign bus.t          = t_bin;
    assign bus.t_bcd      = t_bcd_w;
    assign bus.t_interval = intv_q;
    assign bus.lap_time   = ltime_q;
    assign bus.lap_count  = cnt_q;
    assign bus.lap_ovf    = lovf_q;
    assign bus.running    = running_q;
    assign bus.t_ovf      = t_sat;

endmodule
`default_nettype wire

// File: tb/tb_lap_stopwatch_core.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_lap_stopwatch_core : directed + random bench with queue model  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_lap_stopwatch_core;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIGITS  = 2;
    localparam int LAPS    = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int TMAX    = 99;
    localparam int TMOD    = 128;

    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_PAUSE = 2;

    logic clk;
    logic key2;

    lap_stopwatch_core_if #(.DIGITS(DIGITS), .LAPS(LAPS)) bus ();

    lap_stopwatch_core #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .DIGITS  (DIGITS),
        .LAPS    (LAPS)
    ) dut (
        .clk  (clk),
        .KEY2 (key2),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int m_mode, m_t, m_phase, m_prev, m_int, m_ltime;
    bit m_lovf, m_tovf;
    int m_laps[$];

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | (((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_zero();
        m_mode  = MD_IDLE;
        m_t     = 0;
        m_phase = 0;
        m_prev  = 0;
        m_int   = 0;
        m_ltime = 0;
        m_lovf  = 1'b0;
        m_tovf  = 1'b0;
        m_laps.delete();
    endtask

    task automatic model_step(input bit ss, input bit lp, input bit cl, input int ri, input bit k);
        if (!k) begin
            model_zero();
            return;
        end
        if (cl && m_mode != MD_RUN) begin
            model_zero();
            return;
        end
        m_ltime = (ri < m_laps.size()) ? m_laps[ri] : 0;
        if (m_mode == MD_RUN) begin
            if (lp) begin
                m_laps.push_back(m_t);
                if (m_laps.size() > LAPS) begin
                    void'(m_laps.pop_front());
                    m_lovf = 1'b1;
                end
                m_int  = (m_t - m_prev + TMOD) % TMOD;
                m_prev = m_t;
            end
            m_phase++;
            if (m_phase == DIV) begin
                m_phase = 0;
                if (m_t == TMAX) m_tovf = 1'b1;
                else             m_t++;
            end
        end
        if (ss) m_mode = (m_mode == MD_RUN) ? MD_PAUSE : MD_RUN;
    endtask

    task automatic check_all();
        chk("t",          bus.t,          m_t);
        chk("t_bcd",      bus.t_bcd,      to_bcd(m_t));
        chk("t_interval", bus.t_interval, m_int);
        chk("lap_time",   bus.lap_time,   m_ltime);
        chk("lap_count",  bus.lap_count,  m_laps.size());
        chk("lap_ovf",    bus.lap_ovf,    int'(m_lovf));
        chk("running",    bus.running,    (m_mode == MD_RUN) ? 1 : 0);
        chk("t_ovf",      bus.t_ovf,      int'(m_tovf));
    endtask

    task automatic cyc(input bit ss, input bit lp, input bit cl, input int ri, input bit k);
        bus.start_stop = ss;
        bus.lap        = lp;
        bus.clear      = cl;
        bus.rd_idx     = 2'(ri);
        key2           = k;
        @(posedge clk);
        model_step(ss, lp, cl, ri, k);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    // Idle until the model reaches time tt (and prescaler phase ph if ph >= 0).
    task automatic run_until(input int tt, input int ph);
        int n;
        n = 0;
        while (!(m_t == tt && (ph < 0 || m_phase == ph))) begin
            if (n > 2000) begin
                chk("run_until_timeout", 32'd1, 0);
                return;
            end
            idle(1);
            n++;
        end
    endtask

    task automatic read_lap(input int ri, input int exp);
        cyc(1'b0, 1'b0, 1'b0, ri, 1'b1);
        chk($sformatf("rd_idx%0d", ri), bus.lap_time, exp);
    endtask

    initial begin
        model_zero();
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
        bus.rd_idx     = '0;
        key2           = 1'b0;

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_t", bus.t, 0);
        chk("rst_running", bus.running, 0);

        // run / pause / resume with preserved prescaler phase
        cyc(1, 0, 0, 0, 1);
        idle(35);
        chk("run35_t", bus.t, 3);
        chk("run35_bcd", bus.t_bcd, 8'h03);
        chk("run35_running", bus.running, 1);
        cyc(1, 0, 0, 0, 1);
        idle(50);
        chk("pause_t", bus.t, 3);
        cyc(1, 0, 0, 0, 1);
        idle(7);
        chk("resume_t", bus.t, 4);

        // decimal carry and saturation
        run_until(9, -1);
        chk("bcd9", bus.t_bcd, 8'h09);
        run_until(10, -1);
        chk("bcd10", bus.t_bcd, 8'h10);
        chk("bin10", bus.t, 10);
        run_until(99, -1);
        idle(20);
        chk("sat_t", bus.t, 99);
        chk("sat_ovf", bus.t_ovf, 1);
        chk("sat_running", bus.running, 1);

        // laps at 5, 12, 20
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 1);
        chk("clr_t", bus.t, 0);
        chk("clr_ovf", bus.t_ovf, 0);
        cyc(1, 0, 0, 0, 1);
        run_until(5, -1);
        cyc(0, 1, 0, 0, 1);
        chk("intv5", bus.t_interval, 5);
        run_until(12, -1);
        cyc(0, 1, 0, 0, 1);
        chk("intv7", bus.t_interval, 7);
        run_until(20, -1);
        cyc(0, 1, 0, 0, 1);
        chk("intv8", bus.t_interval, 8);
        chk("cnt3", bus.lap_count, 3);
        read_lap(0, 5);
        read_lap(1, 12);
        read_lap(2, 20);
        read_lap(3, 0);

        // five laps into four slots
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1);
        for (int v = 1; v <= 5; v++) begin
            run_until(v, -1);
            cyc(0, 1, 0, 0, 1);
        end
        chk("cnt_sat", bus.lap_count, 4);
        chk("lap_ovf", bus.lap_ovf, 1);
        read_lap(0, 2);
        read_lap(3, 5);

        // clear ignored in RUN; clear beats start_stop in PAUSE
        cyc(0, 0, 1, 0, 1);
        chk("clr_run_cnt", bus.lap_count, 4);
        chk("clr_run_running", bus.running, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 1);
        chk("cs_t", bus.t, 0);
        chk("cs_cnt", bus.lap_count, 0);
        chk("cs_ovf", bus.lap_ovf, 0);
        chk("cs_running", bus.running, 0);

        // lap coincident with a tick
        cyc(1, 0, 0, 0, 1);
        run_until(6, DIV - 1);
        cyc(0, 1, 0, 0, 1);
        chk("coinc_t", bus.t, 7);
        read_lap(0, 6);

        // reset pulse mid-run
        idle(3);
        cyc(0, 0, 0, 0, 0);
        chk("mrst_t", bus.t, 0);
        chk("mrst_bcd", bus.t_bcd, 0);
        chk("mrst_cnt", bus.lap_count, 0);
        chk("mrst_intv", bus.t_interval, 0);
        chk("mrst_running", bus.running, 0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(15) == 0,
                $urandom_range(5) == 0,
                $urandom_range(19) == 0,
                int'($urandom_range(LAPS - 1)),
                $urandom_range(299) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
